fetch_pc: RTL and testbench



---
 rtl/core_pkg.sv | 13 +
 rtl/next_pc_sel.sv | 29 ++
 rtl/fetch_pc.sv | 88 ++++++++
 tb/tb_fetch_pc.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and state encoding for the fetch stage
package core_pkg;

  localparam int          PC_W        = 32;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next-PC priority mux (jump > branch > sequential)
// plus alignment and IM range check on the selected target.
module next_pc_sel
  import core_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [PC_W-1:0] pc_plus4,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] npc,
  output logic            npc_bad
);

  always_comb begin
    npc = pc_plus4;
    if (jump) begin
      npc = jump_target;
    end else if (branch_taken) begin
      npc = branch_target;
    end
  end

  // Any bit above the IM word index means the fetch would leave IM.
  assign npc_bad = (npc[1:0] != 2'b00) || (npc[PC_W-1:ADDR_W+2] != '0);

endmodule

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter, fetch FSM (RUN/HALT/FAULT), retired
// instruction counter and fault address capture.
module fetch_pc
  import core_pkg::*;
#(
  parameter int          ADDR_W      = 5,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] EBREAK_INST = core_pkg::EBREAK_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  input  logic [31:0]       inst,
  output logic [ADDR_W-1:0] addressIM,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       fault_pc,
  output logic [31:0]       instret
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] npc;
  logic        npc_bad;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_sel #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_sel (
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .npc           (npc),
    .npc_bad       (npc_bad)
  );

  // EBREAK is checked before the redirect so it wins over any jump/branch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instret_d  = instret_q;
    fault_pc_d = fault_pc_q;
    if (state_q == ST_RUN && !stall) begin
      instret_d = instret_q + 32'd1;
      if (inst == EBREAK_INST) begin
        state_d = ST_HALT;
      end else if (npc_bad) begin
        state_d    = ST_FAULT;
        fault_pc_d = npc;
      end else begin
        pc_d = npc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      instret_q  <= 32'd0;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instret_q  <= instret_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign pc        = pc_q;
  assign addressIM = pc_q[ADDR_W+1:2];
  assign halted    = (state_q == ST_HALT);
  assign fault     = (state_q == ST_FAULT);
  assign fault_pc  = fault_pc_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - self-checking bench for fetch_pc with a reference model
module tb_fetch_pc;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam int          IM_BYTES = 4 * 32;

  logic        clk, rst, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target, inst;
  logic [4:0]  addressIM;
  logic [31:0] pc, pc_plus4, fault_pc, instret;
  logic        halted, fault;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = run, 1 = halt, 2 = fault
  int          m_state;
  logic [31:0] m_pc, m_instret, m_fault_pc;

  fetch_pc #(
    .ADDR_W(5),
    .RESET_PC(32'h0000_0000),
    .EBREAK_INST(32'h0010_0073)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .inst          (inst),
    .addressIM     (addressIM),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .halted        (halted),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic [31:0] in);
    logic [31:0] target;
    rst = r; stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; inst = in;
    @(posedge clk);
    if (r) begin
      m_state = 0; m_pc = 32'h0; m_instret = 0; m_fault_pc = 0;
    end else if (m_state == 0 && !s) begin
      m_instret = m_instret + 1;
      if (in == EBREAK) begin
        m_state = 1;
      end else begin
        target = j ? jt : (b ? bt : m_pc + 32'd4);
        if ((target % 4) != 0 || target >= IM_BYTES) begin
          m_state = 2;
          m_fault_pc = target;
        end else begin
          m_pc = target;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0, NOP);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_flags got h=%b f=%b exp 0 0", halted, fault); end
    checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc got %h exp 0", fault_pc); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h exp 4", pc_plus4); end
  endtask

  task automatic test_sequential;
    step(1, 0, 0, 0, 0, 0, NOP);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0, 0, 0, NOP);
      checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, 32'(4 * i)); end
      checks++; if (addressIM !== 5'(i)) begin errors++; $display("FAIL seq_addr got %0d exp %0d", addressIM, i); end
    end
    checks++; if (instret !== 32'd3) begin errors++; $display("FAIL seq_instret got %0d exp 3", instret); end
  endtask

  task automatic test_redirect_priority;
    step(1, 0, 0, 0, 0, 0, NOP);
    step(0, 0, 0, 0, 0, 0, NOP);
    step(0, 0, 0, 0, 0, 0, NOP);
    step(0, 0, 1, 32'h20, 1, 32'h40, NOP);
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL jump_wins_pc got %h exp 40", pc); end
    checks++; if (addressIM !== 5'd16) begin errors++; $display("FAIL jump_wins_addr got %0d exp 16", addressIM); end
    step(0, 0, 1, 32'h24, 0, 0, NOP);
    checks++; if (pc !== 32'h24) begin errors++; $display("FAIL branch_pc got %h exp 24", pc); end
  endtask

  task automatic test_stall;
    step(1, 0, 0, 0, 0, 0, NOP);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, NOP);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 1, 32'h30, EBREAK);
      checks++; if (pc !== 32'h10 || addressIM !== 5'd4) begin errors++; $display("FAIL stall_pc got %h/%0d exp 10/4", pc, addressIM); end
      checks++; if (instret !== 32'd4 || halted !== 1'b0) begin errors++; $display("FAIL stall_instret got %0d h=%b exp 4 h=0", instret, halted); end
    end
    step(0, 0, 1, 32'h04, 0, 0, NOP);
    checks++; if (pc !== 32'h04 || instret !== 32'd5) begin errors++; $display("FAIL stall_release got pc=%h n=%0d exp 4 5", pc, instret); end
  endtask

  task automatic test_halt;
    step(1, 0, 0, 0, 0, 0, NOP);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, NOP);
    step(0, 0, 0, 0, 1, 32'h40, EBREAK);
    checks++; if (halted !== 1'b1 || pc !== 32'h0C) begin errors++; $display("FAIL halt_enter got h=%b pc=%h exp 1 0c", halted, pc); end
    checks++; if (instret !== 32'd4) begin errors++; $display("FAIL halt_instret got %0d exp 4", instret); end
    step(0, 0, 0, 0, 1, 32'h40, NOP);
    checks++; if (halted !== 1'b1 || pc !== 32'h0C || instret !== 32'd4) begin errors++; $display("FAIL halt_hold got h=%b pc=%h n=%0d exp 1 0c 4", halted, pc, instret); end
    step(1, 0, 0, 0, 0, 0, NOP);
    checks++; if (halted !== 1'b0 || pc !== 32'h0 || instret !== 32'd0) begin errors++; $display("FAIL halt_reset got h=%b pc=%h n=%0d exp 0 0 0", halted, pc, instret); end
  endtask

  task automatic test_fault;
    step(1, 0, 0, 0, 0, 0, NOP);
    step(0, 0, 0, 0, 1, 32'h06, NOP);
    checks++; if (fault !== 1'b1 || fault_pc !== 32'h06 || pc !== 32'h0) begin errors++; $display("FAIL misalign got f=%b fpc=%h pc=%h exp 1 06 0", fault, fault_pc, pc); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL misalign_instret got %0d exp 1", instret); end
    step(0, 0, 0, 0, 1, 32'h10, NOP);
    checks++; if (fault !== 1'b1 || pc !== 32'h0 || fault_pc !== 32'h06) begin errors++; $display("FAIL fault_hold got f=%b pc=%h fpc=%h exp 1 0 06", fault, pc, fault_pc); end
    step(1, 0, 0, 0, 0, 0, NOP);
    step(0, 0, 0, 0, 1, 32'h7C, NOP);
    checks++; if (pc !== 32'h7C || addressIM !== 5'd31) begin errors++; $display("FAIL last_word got pc=%h a=%0d exp 7c 31", pc, addressIM); end
    step(0, 0, 0, 0, 0, 0, NOP);
    checks++; if (fault !== 1'b1 || fault_pc !== 32'h80 || pc !== 32'h7C) begin errors++; $display("FAIL seq_off_end got f=%b fpc=%h pc=%h exp 1 80 7c", fault, fault_pc, pc); end
    step(1, 0, 0, 0, 0, 0, NOP);
    step(0, 0, 1, 32'h0000_1000, 0, 0, NOP);
    checks++; if (fault !== 1'b1 || fault_pc !== 32'h1000) begin errors++; $display("FAIL range got f=%b fpc=%h exp 1 1000", fault, fault_pc); end
  endtask

  task automatic test_reset_priority;
    step(1, 0, 0, 0, 0, 0, NOP);
    step(0, 0, 0, 0, 0, 0, NOP);
    step(1, 0, 1, 32'h20, 1, 32'h40, EBREAK);
    checks++; if (pc !== 32'h0 || instret !== 32'd0 || halted !== 1'b0) begin errors++; $display("FAIL rst_prio got pc=%h n=%0d h=%b exp 0 0 0", pc, instret, halted); end
  endtask

  function automatic logic [31:0] rand_target();
    int k = $urandom_range(0, 9);
    if (k < 7) return 32'(4 * $urandom_range(0, 31));
    if (k < 9) return 32'($urandom_range(0, 127));
    return $urandom;
  endfunction

  task automatic test_random;
    logic        r, s, b, j;
    logic [31:0] bt, jt, in;
    step(1, 0, 0, 0, 0, 0, NOP);
    for (int i = 0; i < 400; i++) begin
      r  = (m_state != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 4) == 0);
      b  = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 5) == 0);
      bt = rand_target();
      jt = rand_target();
      in = ($urandom_range(0, 24) == 0) ? EBREAK : (($urandom_range(0, 1) == 0) ? NOP : $urandom);
      step(r, s, b, bt, j, jt, in);
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, pc, m_pc); end
      checks++; if (addressIM !== 5'(m_pc / 4)) begin errors++; $display("FAIL rnd_addr cyc %0d got %0d exp %0d", i, addressIM, m_pc / 4); end
      checks++; if (pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc_plus4 cyc %0d got %h exp %h", i, pc_plus4, m_pc + 32'd4); end
      checks++; if (instret !== m_instret) begin errors++; $display("FAIL rnd_instret cyc %0d got %0d exp %0d", i, instret, m_instret); end
      checks++; if (halted !== (m_state == 1) || fault !== (m_state == 2)) begin errors++; $display("FAIL rnd_state cyc %0d got h=%b f=%b exp st=%0d", i, halted, fault, m_state); end
      checks++; if (fault_pc !== m_fault_pc) begin errors++; $display("FAIL rnd_fault_pc cyc %0d got %h exp %h", i, fault_pc, m_fault_pc); end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0; inst = NOP;
    m_state = 0; m_pc = 0; m_instret = 0; m_fault_pc = 0;
    test_reset();
    test_sequential();
    test_redirect_priority();
    test_stall();
    test_halt();
    test_fault();
    test_reset_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
